// File: rtl/main_pkg.sv
// Shared types and widths for the main_int request/response protocol.
package main_pkg;
  localparam int ADDR_W = 31;
  localparam int DATA_W = 32;

  typedef enum logic {CMD_RD = 1'b0, CMD_WR = 1'b1} cmd_e;
  typedef enum {IDLE, WAIT, GRANT} ack_state_e;
endpackage

// File: rtl/mem_slave_responder_if.sv
// main_int slave port bundle: request side from the crossbar, ack/response back.
interface mem_slave_responder_if;
  import main_pkg::*;

  logic              req_i;
  logic [ADDR_W-1:0] addr_i;
  cmd_e              cmd_i;
  logic [DATA_W-1:0] wdata_i;
  logic              ack_o;
  logic              resp_o;
  logic [DATA_W-1:0] rdata_o;

  modport master (output req_i, addr_i, cmd_i, wdata_i, input  ack_o, resp_o, rdata_o);
  modport slave  (input  req_i, addr_i, cmd_i, wdata_i, output ack_o, resp_o, rdata_o);
endinterface

// File: rtl/resp_pipe.sv
// Read-response latency pipe plus outstanding-read counter.
// word is the RAM output register, i.e. already one stage past the accept edge.
module resp_pipe
  import main_pkg::*;
#(
  parameter int RD_LAT = 2,
  parameter int QDEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push,
  input  logic [DATA_W-1:0] word,
  output logic              resp,
  output logic [DATA_W-1:0] rdata,
  output logic              q_full
);
  localparam int STAGES = RD_LAT - 1;
  localparam int QW     = $clog2(QDEPTH + 1);

  logic [STAGES:0]   vld_pipe;
  logic [QW-1:0]     q_cnt;
  logic [DATA_W-1:0] dat_out;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= push;
      for (int k = 1; k <= STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  // Data free-runs alongside the valid bits; only the valid lane is reset.
  generate
    if (STAGES == 0) begin : g_direct
      assign dat_out = word;
    end else begin : g_shift
      logic [STAGES:1][DATA_W-1:0] dat_pipe;
      always_ff @(posedge clk_i) begin
        dat_pipe[1] <= word;
        for (int k = 2; k <= STAGES; k++) dat_pipe[k] <= dat_pipe[k-1];
      end
      assign dat_out = dat_pipe[STAGES];
    end
  endgenerate

  assign resp  = vld_pipe[STAGES];
  assign rdata = resp ? dat_out : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)              q_cnt <= '0;
    else if (push && !resp) q_cnt <= q_cnt + QW'(1);
    else if (!push && resp) q_cnt <= q_cnt - QW'(1);
  end

  assign q_full = (q_cnt == QW'(QDEPTH));
endmodule

// File: rtl/mem_slave_responder.sv
// Memory-backed main_int responder: ack FSM with programmable wait states,
// single-port RAM, and in-order fixed-latency read responses.
module mem_slave_responder
  import main_pkg::*;
#(
  parameter int DEPTH    = 1024,
  parameter int ACK_WAIT = 0,
  parameter int RD_LAT   = 2,
  parameter int QDEPTH   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  mem_slave_responder_if.slave  bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = (ACK_WAIT > 1) ? $clog2(ACK_WAIT) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word;
  logic [IW-1:0]     idx;
  ack_state_e        state;
  logic [CW-1:0]     cnt;
  logic              grant, is_rd, ack, rd_acc, wr_acc, q_full;
  logic              unused_addr;

  assign idx         = bus.addr_i[IW+1:2];
  assign unused_addr = ^{bus.addr_i[ADDR_W-1:IW+2], bus.addr_i[1:0]};
  assign is_rd       = (bus.cmd_i == CMD_RD);

  // WAIT with cnt==0 is the last wait cycle and already grants, so ack lands
  // on cycle ACK_WAIT+1 of a held request.
  always_comb begin
    case (state)
      GRANT:   grant = 1'b1;
      WAIT:    grant = (cnt == '0);
      default: grant = (ACK_WAIT == 0);
    endcase
  end

  assign ack        = bus.req_i & grant & ~(is_rd & q_full) & ~rst_i;
  assign rd_acc     = ack & is_rd;
  assign wr_acc     = ack & ~is_rd;
  assign bus.ack_o  = ack;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.req_i && ACK_WAIT != 0) begin
          state <= WAIT;
          cnt   <= CW'(ACK_WAIT > 0 ? ACK_WAIT - 1 : 0);
        end
        WAIT: begin
          if (!bus.req_i)     state <= IDLE;
          else if (cnt != '0) cnt   <= cnt - CW'(1);
          else                state <= ack ? IDLE : GRANT;
        end
        GRANT: if (!bus.req_i || ack) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Plain RAM block, no reset, so it maps onto block RAM with a registered read.
  always_ff @(posedge clk_i) begin
    if (wr_acc) mem[idx] <= bus.wdata_i;
    if (rd_acc) rd_word  <= mem[idx];
  end

  resp_pipe #(.RD_LAT(RD_LAT), .QDEPTH(QDEPTH)) u_pipe (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push   (rd_acc),
    .word   (rd_word),
    .resp   (bus.resp_o),
    .rdata  (bus.rdata_o),
    .q_full (q_full)
  );
endmodule

// File: tb/tb_mem_slave_responder.sv
// Bench for mem_slave_responder: three configurations, directed vectors and a
// random master checked every cycle against a transaction-level model.
module tb_mem_slave_responder;
  import main_pkg::*;

  localparam int ND    = 3;
  localparam int DEPTH = 1024;
  localparam int AW [ND] = '{0, 3, 0};
  localparam int RL [ND] = '{2, 2, 6};
  localparam int QD [ND] = '{4, 4, 2};

  logic        clk = 1'b0;
  logic        rst;
  logic        req   [ND];
  logic        cmd   [ND];
  logic [30:0] addr  [ND];
  logic [31:0] wdata [ND];
  logic        o_ack [ND], o_resp [ND];
  logic [31:0] o_rdata [ND];
  logic        s_ack [ND], s_resp [ND];
  logic [31:0] s_rdata [ND];

  always #5 clk = ~clk;

  mem_slave_responder_if bus0 ();
  mem_slave_responder_if bus1 ();
  mem_slave_responder_if bus2 ();

  assign bus0.req_i = req[0]; assign bus0.addr_i = addr[0];
  assign bus0.cmd_i = cmd_e'(cmd[0]); assign bus0.wdata_i = wdata[0];
  assign bus1.req_i = req[1]; assign bus1.addr_i = addr[1];
  assign bus1.cmd_i = cmd_e'(cmd[1]); assign bus1.wdata_i = wdata[1];
  assign bus2.req_i = req[2]; assign bus2.addr_i = addr[2];
  assign bus2.cmd_i = cmd_e'(cmd[2]); assign bus2.wdata_i = wdata[2];

  assign o_ack[0] = bus0.ack_o; assign o_resp[0] = bus0.resp_o; assign o_rdata[0] = bus0.rdata_o;
  assign o_ack[1] = bus1.ack_o; assign o_resp[1] = bus1.resp_o; assign o_rdata[1] = bus1.rdata_o;
  assign o_ack[2] = bus2.ack_o; assign o_resp[2] = bus2.resp_o; assign o_rdata[2] = bus2.rdata_o;

  mem_slave_responder #(.DEPTH(1024), .ACK_WAIT(0), .RD_LAT(2), .QDEPTH(4))
    dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0));
  mem_slave_responder #(.DEPTH(1024), .ACK_WAIT(3), .RD_LAT(2), .QDEPTH(4))
    dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));
  mem_slave_responder #(.DEPTH(1024), .ACK_WAIT(0), .RD_LAT(6), .QDEPTH(2))
    dut2 (.clk_i(clk), .rst_i(rst), .bus(bus2));

  // Model state: cycles the current request has been held, a FIFO of pending
  // reads (due cycle + data), and a word-addressed memory image.
  int          cyc, total, bad;
  int          held  [ND];
  int          q_due [ND][16];
  logic [31:0] q_dat [ND][16];
  int          q_hd  [ND], q_n [ND];
  logic [31:0] m_mem   [ND][DEPTH];
  bit          m_known [ND][DEPTH];
  bit          m_ack   [ND];

  typedef struct {
    int          d;
    bit          wr;
    logic [30:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rd;
  } vec_t;
  vec_t tv [12];

  int          st_ack [4], st_resp [4];
  logic [31:0] st_dat [4];
  int          max_out;
  int          e4_ack  [4] = '{0, 1, 7, 8};
  int          e4_resp [4] = '{6, 7, 13, 14};

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_model();
    for (int d = 0; d < ND; d++) begin
      logic        e_ack, e_resp;
      logic [31:0] e_rd;
      int          w;
      e_ack = 1'b0; e_resp = 1'b0; e_rd = '0;
      w = int'(addr[d] >> 2) % DEPTH;
      if (rst) begin
        q_n[d] = 0; held[d] = 0;
      end else begin
        held[d] = req[d] ? held[d] + 1 : 0;
        e_ack = req[d] && (held[d] > AW[d]) && (cmd[d] || q_n[d] < QD[d]);
        if (q_n[d] > 0 && q_due[d][q_hd[d]] == cyc) begin
          e_resp = 1'b1;
          e_rd   = q_dat[d][q_hd[d]];
        end
      end
      s_ack[d] = o_ack[d]; s_resp[d] = o_resp[d]; s_rdata[d] = o_rdata[d];
      chk($sformatf("model ack dut%0d", d),   s_ack[d],   e_ack);
      chk($sformatf("model resp dut%0d", d),  s_resp[d],  e_resp);
      chk($sformatf("model rdata dut%0d", d), s_rdata[d], e_rd);
      m_ack[d] = e_ack;
      if (e_resp) begin
        q_hd[d] = (q_hd[d] + 1) % 16;
        q_n[d]--;
      end
      if (e_ack) begin
        held[d] = 0;
        if (cmd[d]) begin
          m_mem[d][w]   = wdata[d];
          m_known[d][w] = 1'b1;
        end else begin
          q_due[d][(q_hd[d] + q_n[d]) % 16] = cyc + RL[d];
          q_dat[d][(q_hd[d] + q_n[d]) % 16] = m_mem[d][w];
          q_n[d]++;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_model();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic xact(int d, bit wr, logic [30:0] a, logic [31:0] wd,
                      int exp_lat, logic [31:0] exp_rd, string nm);
    int n;
    bit got;
    req[d] = 1'b1; cmd[d] = wr; addr[d] = a; wdata[d] = wd;
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      tick();
      if (s_ack[d]) got = 1'b1;
      else n++;
    end
    req[d] = 1'b0;
    chk({nm, " ack latency"}, n, exp_lat);
    if (!wr && got) begin
      n = 0; got = 1'b0;
      while (!got && n < 20) begin
        tick();
        n++;
        if (s_resp[d]) got = 1'b1;
      end
      chk({nm, " resp latency"}, n, RL[d]);
      chk({nm, " rdata"}, s_rdata[d], exp_rd);
    end
  endtask

  task automatic stream(int d, int n, logic [30:0] base);
    int t, nxt, nr, outst;
    t = 0; nxt = 0; nr = 0; outst = 0; max_out = 0;
    for (int i = 0; i < 4; i++) begin st_ack[i] = -1; st_resp[i] = -1; st_dat[i] = '0; end
    while (nr < n && t < 80) begin
      req[d] = (nxt < n); cmd[d] = 1'b0; addr[d] = base + 31'(4 * nxt);
      tick();
      if (s_ack[d] && nxt < n) begin st_ack[nxt] = t; nxt++; outst++; end
      if (s_resp[d]) begin
        if (nr < 4) begin st_resp[nr] = t; st_dat[nr] = s_rdata[d]; end
        nr++; outst--;
      end
      if (outst > max_out) max_out = outst;
      t++;
    end
    req[d] = 1'b0;
    chk("stream resp count", nr, n);
  endtask

  task automatic pick_new(int d);
    int w;
    logic [30:0] a;
    if ($urandom_range(3) == 0) begin
      req[d] = 1'b0;
      return;
    end
    w = $urandom_range(15);
    a = 31'($urandom);
    a[11:2] = 10'(w);
    req[d] = 1'b1; addr[d] = a; wdata[d] = $urandom;
    cmd[d] = ($urandom_range(1) == 1) || !m_known[d][w];
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, first;
    cyc = 0; total = 0; bad = 0;
    for (int d = 0; d < ND; d++) begin
      req[d] = 1'b0; cmd[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
      held[d] = 0; q_hd[d] = 0; q_n[d] = 0; m_ack[d] = 1'b0;
    end
    tv[0]  = '{0, 1'b1, 31'h10,   32'hDEADBEEF, 0, 32'h0};
    tv[1]  = '{0, 1'b0, 31'h10,   32'h0,        0, 32'hDEADBEEF};
    tv[2]  = '{1, 1'b1, 31'h20,   32'h12345678, 3, 32'h0};
    tv[3]  = '{1, 1'b0, 31'h20,   32'h0,        3, 32'h12345678};
    tv[4]  = '{0, 1'b1, 31'h1004, 32'h55,       0, 32'h0};
    tv[5]  = '{0, 1'b0, 31'h4,    32'h0,        0, 32'h55};
    tv[6]  = '{0, 1'b1, 31'h7,    32'hA5A5A5A5, 0, 32'h0};
    tv[7]  = '{0, 1'b0, 31'h4,    32'h0,        0, 32'hA5A5A5A5};
    tv[8]  = '{2, 1'b1, 31'h3FFC, 32'hCAFEF00D, 0, 32'h0};
    tv[9]  = '{2, 1'b0, 31'hFFC,  32'h0,        0, 32'hCAFEF00D};
    tv[10] = '{1, 1'b1, 31'h0,    32'h1,        3, 32'h0};
    tv[11] = '{1, 1'b0, 31'h1000, 32'h0,        3, 32'h1};

    // Reset: hold a read request on dut0 to show ack is forced low.
    rst = 1'b1;
    req[0] = 1'b1;
    tick();
    chk("reset ack",   s_ack[0],   1'b0);
    chk("reset resp",  s_resp[0],  1'b0);
    chk("reset rdata", s_rdata[0], 32'h0);
    tick();
    rst = 1'b0; req[0] = 1'b0;
    tick();

    for (int i = 0; i < 12; i++)
      xact(tv[i].d, tv[i].wr, tv[i].addr, tv[i].wdata, tv[i].lat, tv[i].rd,
           $sformatf("vec%0d", i));

    // Held write request with ACK_WAIT=3: one ack per 4 cycles.
    req[1] = 1'b1; cmd[1] = 1'b1; addr[1] = 31'h40; wdata[1] = 32'h77;
    n = 0; first = -1;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (s_ack[1]) begin n++; if (first < 0) first = t; end
    end
    req[1] = 1'b0;
    chk("held req ack count", n, 2);
    chk("held req first ack", first, 3);

    // Back-to-back writes then reads on dut0.
    n = 0;
    for (int i = 0; i < 4; i++) begin
      req[0] = 1'b1; cmd[0] = 1'b1; addr[0] = 31'(4 * i); wdata[0] = 32'(i + 1);
      tick();
      if (s_ack[0]) n++;
    end
    req[0] = 1'b0;
    chk("b2b write acks", n, 4);
    stream(0, 4, 31'h0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b2b read ack t%0d", i),  st_ack[i],  i);
      chk($sformatf("b2b read resp t%0d", i), st_resp[i], i + 2);
      chk($sformatf("b2b read data %0d", i),  st_dat[i],  32'(i + 1));
    end

    // Queue backpressure on dut2 (RD_LAT=6, QDEPTH=2).
    for (int i = 0; i < 4; i++)
      xact(2, 1'b1, 31'(32'h40 + 4 * i), 32'(32'h11 * (i + 1)), 0, 32'h0, "qfull preload");
    stream(2, 4, 31'h40);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("qfull ack t%0d", i),  st_ack[i],  e4_ack[i]);
      chk($sformatf("qfull resp t%0d", i), st_resp[i], e4_resp[i]);
      chk($sformatf("qfull data %0d", i),  st_dat[i],  32'(32'h11 * (i + 1)));
    end
    chk("qfull max outstanding", max_out, 2);

    // Reset with two reads in flight on dut0.
    req[0] = 1'b1; cmd[0] = 1'b0; addr[0] = 31'h0;
    tick();
    chk("rst seq ack r0", s_ack[0], 1'b1);
    addr[0] = 31'h4;
    tick();
    chk("rst seq ack r1", s_ack[0], 1'b1);
    addr[0] = 31'h8; rst = 1'b1;
    tick();
    chk("rst seq ack in reset",  s_ack[0],  1'b0);
    chk("rst seq resp in reset", s_resp[0], 1'b0);
    tick();
    rst = 1'b0; req[0] = 1'b0;
    n = 0;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (s_resp[0]) n++;
    end
    chk("rst seq resp after release", n, 0);
    xact(0, 1'b0, 31'h10, 32'h0, 0, 32'hDEADBEEF, "rst seq read");

    // Random traffic on all three configurations.
    for (int c = 0; c < 1500; c++) begin
      for (int d = 0; d < ND; d++)
        if (!req[d] || m_ack[d]) pick_new(d);
      tick();
    end
    for (int d = 0; d < ND; d++) req[d] = 1'b0;
    for (int t = 0; t < 20; t++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
